// File: rtl/out_pkg.sv
// Shared definitions for the scanned hex display driver: blank pattern and slot-vector helpers.
package out_pkg;

  localparam logic [7:0] BLANK_SEG = 8'h00;

  // Upper bound on SLOTS; slot vectors are carried at this width through the helpers.
  localparam int unsigned MAX_SLOTS = 64;

  typedef logic [MAX_SLOTS-1:0] slot_vec_t;

  // First occupied slot in circular order ptr+1 .. ptr; returns ptr if none is occupied.
  function automatic int unsigned next_occupied(input int unsigned ptr,
                                                input slot_vec_t   occ_vec,
                                                input int unsigned slots);
    int unsigned res;
    int unsigned idx;
    slot_vec_t   sh;
    res = ptr;
    // Walk from the far end so the nearest occupied slot is the one left in res.
    for (int unsigned i = slots; i >= 1; i--) begin
      idx = ptr + i;
      if (idx >= slots) idx = idx - slots;
      sh = occ_vec >> idx;
      if (sh[0]) res = idx;
    end
    return res;
  endfunction

  function automatic slot_vec_t onehot(input int unsigned sel);
    return slot_vec_t'(1) << sel;
  endfunction

endpackage

// File: rtl/out_scan_mux_if.sv
// Write channel of the scanned display driver: valid/ready handshake plus error pulse.
interface out_scan_mux_if #(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned DIGITS = 4
) ();

  localparam int unsigned SEL_W = $clog2(SLOTS);

  logic                      wr_valid;
  logic                      wr_ready;
  logic [SEL_W-1:0]          wr_sel;
  logic [BANKS-1:0]          wr_bank_en;
  logic [BANKS*4*DIGITS-1:0] wr_data;
  logic                      wr_err;

  modport master (
    output wr_valid, wr_sel, wr_bank_en, wr_data,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_sel, wr_bank_en, wr_data,
    output wr_ready, wr_err
  );

endinterface

// File: rtl/out_scan_mux_seg7.sv
// Hex nibble to seven-segment pattern {dp,g,f,e,d,c,b,a}, active high; blank when display is low.
module out_scan_mux_seg7
  import out_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       display_i,
  output logic [7:0] seg_o
);

  logic [7:0] pattern;

  always_comb begin
    pattern = BLANK_SEG;
    case (nibble_i)
      4'h0: pattern = 8'h3F;
      4'h1: pattern = 8'h06;
      4'h2: pattern = 8'h5B;
      4'h3: pattern = 8'h4F;
      4'h4: pattern = 8'h66;
      4'h5: pattern = 8'h6D;
      4'h6: pattern = 8'h7D;
      4'h7: pattern = 8'h07;
      4'h8: pattern = 8'h7F;
      4'h9: pattern = 8'h6F;
      4'hA: pattern = 8'h77;
      4'hB: pattern = 8'h7C;
      4'hC: pattern = 8'h39;
      4'hD: pattern = 8'h5E;
      4'hE: pattern = 8'h79;
      4'hF: pattern = 8'h71;
      default: pattern = BLANK_SEG;
    endcase
  end

  assign seg_o = display_i ? pattern : BLANK_SEG;

endmodule

// File: rtl/out_scan_mux.sv
// Time-multiplexed hex display driver: SLOTS stored values scanned onto BANKS seven-segment banks,
// each slot held for DWELL clocks. All display outputs are registered.
module out_scan_mux
  import out_pkg::*;
#(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DWELL  = 1024,
  localparam int unsigned SEL_W = $clog2(SLOTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  out_scan_mux_if.slave             wr,
  input  logic                      clr,
  input  logic                      freeze,
  input  logic                      skip_empty,
  output logic [BANKS*DIGITS*8-1:0] led,
  output logic [SLOTS-1:0]          seg_sel,
  output logic [SEL_W-1:0]          cur_slot
);

  localparam int unsigned BANK_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DWELL + 1);
  localparam int unsigned NUM_SEG = BANKS * DIGITS;

  typedef logic [BANK_W-1:0] bank_val_t;

  bank_val_t        slot_data  [SLOTS][BANKS];
  logic [BANKS-1:0] slot_valid [SLOTS];
  logic [SLOTS-1:0] occ;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]         ptr_q, ptr_d;
  logic                     wr_err_q;
  logic [NUM_SEG*8-1:0]     led_q, led_d;
  logic [SLOTS-1:0]         seg_sel_q, seg_sel_d;
  logic [SEL_W-1:0]         cur_slot_q;

  logic wr_accept;
  logic sel_in_range;
  logic wr_store;

  // clr owns the cycle: a simultaneous write is refused rather than racing the clear.
  assign wr.wr_ready   = ~clr;
  assign wr_accept     = wr.wr_valid & wr.wr_ready;
  assign sel_in_range  = 32'(wr.wr_sel) < SLOTS;
  assign wr_store      = wr_accept & sel_in_range;

  // Per-slot, per-bank storage with its own valid flag.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      bank_val_t data_q;
      logic      valid_q;

      always_ff @(posedge clock) begin
        if (!reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (clr) begin
          valid_q <= 1'b0;
        end else if (wr_store && (wr.wr_sel == SEL_W'(s)) && wr.wr_bank_en[b]) begin
          valid_q <= 1'b1;
          data_q  <= wr.wr_data[b*BANK_W +: BANK_W];
        end
      end

      assign slot_data[s][b]  = data_q;
      assign slot_valid[s][b] = valid_q;
    end

    assign occ[s] = |slot_valid[s];
  end

  // Dwell counter and scan pointer; the skip search sees flags from the start of the cycle.
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (!freeze) begin
      if (cnt_q == CNT_W'(DWELL - 1)) begin
        cnt_d = '0;
        if (skip_empty) begin
          ptr_d = SEL_W'(next_occupied(32'(ptr_q), MAX_SLOTS'(occ), SLOTS));
        end else if (32'(ptr_q) == SLOTS - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_dec_bank
    for (genvar d = 0; d < DIGITS; d++) begin : g_dec_digit
      out_scan_mux_seg7 u_seg7 (
        .nibble_i  (slot_data[ptr_q][b][BANK_W-4-4*d +: 4]),
        .display_i (slot_valid[ptr_q][b]),
        .seg_o     (led_d[(b*DIGITS+d)*8 +: 8])
      );
    end
  end

  always_comb begin
    seg_sel_d = '0;
    if (occ[ptr_q]) seg_sel_d = SLOTS'(onehot(32'(ptr_q)));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q      <= '0;
      ptr_q      <= '0;
      wr_err_q   <= 1'b0;
      led_q      <= {NUM_SEG{BLANK_SEG}};
      seg_sel_q  <= '0;
      cur_slot_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      wr_err_q   <= wr_accept & ~sel_in_range;
      led_q      <= led_d;
      seg_sel_q  <= seg_sel_d;
      cur_slot_q <= ptr_q;
    end
  end

  assign wr.wr_err = wr_err_q;
  assign led       = led_q;
  assign seg_sel   = seg_sel_q;
  assign cur_slot  = cur_slot_q;

endmodule

// File: tb/tb_out_scan_mux.sv
// Bench for out_scan_mux (SLOTS=8, BANKS=2, DIGITS=4, DWELL=4): cycle scoreboard plus directed cases.
module tb_out_scan_mux;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic        clock;
  logic        reset;
  logic        clr;
  logic        freeze;
  logic        skip_empty;
  logic [63:0] led;
  logic [7:0]  seg_sel;
  logic [2:0]  cur_slot;

  int checks;
  int failures;

  out_scan_mux_if #(.SLOTS(8), .BANKS(2), .DIGITS(4)) wr_if ();

  out_scan_mux #(.SLOTS(8), .BANKS(2), .DIGITS(4), .DWELL(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr         (wr_if),
    .clr        (clr),
    .freeze     (freeze),
    .skip_empty (skip_empty),
    .led        (led),
    .seg_sel    (seg_sel),
    .cur_slot   (cur_slot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: behavioural model of the display ----------------
  typedef struct {
    logic [63:0] led;
    logic [7:0]  seg_sel;
    logic [2:0]  cur;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_data  [8][2];
  logic        m_valid [8][2];
  int          m_ptr;
  int          m_cnt;

  always @(posedge clock) begin : sb_model
    exp_t       e;
    logic [7:0] occ_m;
    int         np;
    bit         found;
    for (int s = 0; s < 8; s++) occ_m[s] = m_valid[s][0] | m_valid[s][1];
    if (!reset) begin
      e = '{led: 64'h0, seg_sel: 8'h0, cur: 3'h0, err: 1'b0};
      for (int s = 0; s < 8; s++) begin
        for (int b = 0; b < 2; b++) begin
          m_valid[s][b] = 1'b0;
          m_data[s][b]  = 16'h0;
        end
      end
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      e.cur     = 3'(m_ptr);
      e.seg_sel = occ_m[m_ptr] ? (8'h01 << m_ptr) : 8'h00;
      e.err     = 1'b0;
      e.led     = 64'h0;
      for (int b = 0; b < 2; b++)
        for (int d = 0; d < 4; d++)
          if (m_valid[m_ptr][b]) e.led[(b*4+d)*8 +: 8] = SEG_TAB[m_data[m_ptr][b][15-4*d -: 4]];
      if (!freeze) begin
        if (m_cnt == 3) begin
          m_cnt = 0;
          if (skip_empty) begin
            found = 0;
            np    = m_ptr;
            for (int k = 1; k <= 8; k++) begin
              if (!found && occ_m[(m_ptr + k) % 8]) begin
                np    = (m_ptr + k) % 8;
                found = 1;
              end
            end
            m_ptr = np;
          end else begin
            m_ptr = (m_ptr + 1) % 8;
          end
        end else begin
          m_cnt++;
        end
      end
      if (clr) begin
        for (int s = 0; s < 8; s++) begin
          m_valid[s][0] = 1'b0;
          m_valid[s][1] = 1'b0;
        end
      end else if (wr_if.wr_valid) begin
        for (int b = 0; b < 2; b++) begin
          if (wr_if.wr_bank_en[b]) begin
            m_valid[wr_if.wr_sel][b] = 1'b1;
            m_data[wr_if.wr_sel][b]  = wr_if.wr_data[b*16 +: 16];
          end
        end
      end
    end
    sb_q.push_back(e);
  end

  always @(negedge clock) begin : sb_check
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_led", led, e.led);
      check("sb_seg_sel", 64'(seg_sel), 64'(e.seg_sel));
      check("sb_cur_slot", 64'(cur_slot), 64'(e.cur));
      check("sb_wr_err", 64'(wr_if.wr_err), 64'(e.err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_write(input logic [2:0] sel, input logic [1:0] en, input logic [31:0] data);
    wr_if.wr_valid   = 1'b1;
    wr_if.wr_sel     = sel;
    wr_if.wr_bank_en = en;
    wr_if.wr_data    = data;
    @(negedge clock);
    wr_if.wr_valid   = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  // Bounded wait for cur_slot==slot; fresh demands the first sample of a new run.
  task automatic wait_slot(input logic [2:0] slot, input bit fresh, input string tag);
    logic [2:0] prev;
    bit         hit;
    hit  = 0;
    prev = cur_slot;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clock);
      if (cur_slot == slot && (!fresh || prev != slot)) hit = 1;
      prev = cur_slot;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s: cur_slot never reached %0d (last %0d)", tag, slot, cur_slot);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  en;
    logic [31:0] data;
    logic [63:0] exp_led;
    logic [7:0]  exp_sel;
  } vec_t;

  vec_t vecs [4];

  initial begin : stim
    logic [2:0] ref_slot;
    logic [2:0] exp_slot;

    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clr      = 1'b0;
    freeze   = 1'b0;
    skip_empty       = 1'b0;
    wr_if.wr_valid   = 1'b0;
    wr_if.wr_sel     = 3'd0;
    wr_if.wr_bank_en = 2'b00;
    wr_if.wr_data    = 32'h0;

    vecs[0] = '{sel: 3'd3, en: 2'b01, data: {16'hBEEF, 16'h1234},
                exp_led: 64'h00000000_664F5B06, exp_sel: 8'h08};
    vecs[1] = '{sel: 3'd5, en: 2'b10, data: {16'h0F9A, 16'h5555},
                exp_led: 64'h776F713F_00000000, exp_sel: 8'h20};
    vecs[2] = '{sel: 3'd1, en: 2'b11, data: {16'hC0DE, 16'h8B67},
                exp_led: 64'h795E3F39_077D7C7F, exp_sel: 8'h02};
    vecs[3] = '{sel: 3'd6, en: 2'b00, data: {16'hFFFF, 16'hFFFF},
                exp_led: 64'h0, exp_sel: 8'h00};

    // Reset held three clocks, then free-run scan with nothing stored.
    repeat (3) @(negedge clock);
    check("rst_led", led, 64'h0);
    check("rst_seg_sel", 64'(seg_sel), 64'h0);
    check("rst_cur_slot", 64'(cur_slot), 64'h0);
    check("rst_wr_ready", 64'(wr_if.wr_ready), 64'h1);
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      check("empty_scan_slot", 64'(cur_slot), 64'(j / 4));
      check("empty_scan_sel", 64'(seg_sel), 64'h0);
    end

    // Table of writes, each checked when its slot comes round.
    for (int v = 0; v < 4; v++) begin
      do_write(vecs[v].sel, vecs[v].en, vecs[v].data);
      wait_slot(vecs[v].sel, 1'b0, "vec_wait");
      check("vec_led", led, vecs[v].exp_led);
      check("vec_seg_sel", 64'(seg_sel), 64'(vecs[v].exp_sel));
    end

    // Skip-empty scan over slots 2 and 6.
    do_clr();
    do_write(3'd2, 2'b11, {16'h2020, 16'hA0A0});
    do_write(3'd6, 2'b01, {16'h0000, 16'h6666});
    skip_empty = 1'b1;
    wait_slot(3'd2, 1'b1, "skip_wait");
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clock);
      exp_slot = ((i / 4) % 2 == 1) ? 3'd6 : 3'd2;
      check("skip_slot", 64'(cur_slot), 64'(exp_slot));
      check("skip_sel", 64'(seg_sel), 64'(8'h01 << exp_slot));
    end
    do_clr();
    @(negedge clock);
    check("clr_led", led, 64'h0);
    check("clr_seg_sel", 64'(seg_sel), 64'h0);
    @(negedge clock);
    ref_slot = cur_slot;
    repeat (8) begin
      @(negedge clock);
      check("clr_ptr_hold", 64'(cur_slot), 64'(ref_slot));
    end
    skip_empty = 1'b0;

    // clr beats a same-cycle write; slot 5 must stay empty with no error.
    clr              = 1'b1;
    wr_if.wr_valid   = 1'b1;
    wr_if.wr_sel     = 3'd5;
    wr_if.wr_bank_en = 2'b11;
    wr_if.wr_data    = 32'h5A5A_5A5A;
    #1;
    check("clr_wr_ready", 64'(wr_if.wr_ready), 64'h0);
    @(negedge clock);
    clr            = 1'b0;
    wr_if.wr_valid = 1'b0;
    @(negedge clock);
    check("clr_wr_err", 64'(wr_if.wr_err), 64'h0);
    wait_slot(3'd5, 1'b0, "slot5_wait");
    check("slot5_led", led, 64'h0);
    check("slot5_sel", 64'(seg_sel), 64'h0);

    // Write slot 7 while it is on display: new digits one clock after accept.
    wait_slot(3'd7, 1'b1, "slot7_wait");
    do_write(3'd7, 2'b11, {16'h2222, 16'h9876});
    check("live_led_pre", led, 64'h0);
    @(negedge clock);
    check("live_led", led, 64'h5B5B5B5B_7D077F6F);
    check("live_sel", 64'(seg_sel), 64'h80);
    check("live_slot", 64'(cur_slot), 64'h7);

    // Freeze with the dwell count at 2, then the advance lands two clocks after release.
    wait_slot(3'd2, 1'b1, "frz_wait");
    @(negedge clock);
    ref_slot = cur_slot;
    freeze   = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("frz_hold", 64'(cur_slot), 64'(ref_slot));
    end
    freeze = 1'b0;
    @(negedge clock);
    check("frz_rel1", 64'(cur_slot), 64'(ref_slot));
    @(negedge clock);
    check("frz_rel2", 64'(cur_slot), 64'(ref_slot));
    @(negedge clock);
    check("frz_adv", 64'(cur_slot), 64'(3'(ref_slot + 3'd1)));

    // Reset mid-scan with a write in the same cycle.
    reset            = 1'b0;
    wr_if.wr_valid   = 1'b1;
    wr_if.wr_sel     = 3'd0;
    wr_if.wr_bank_en = 2'b11;
    wr_if.wr_data    = 32'h1234_5678;
    @(negedge clock);
    reset          = 1'b1;
    wr_if.wr_valid = 1'b0;
    check("mid_rst_led", led, 64'h0);
    check("mid_rst_sel", 64'(seg_sel), 64'h0);
    check("mid_rst_slot", 64'(cur_slot), 64'h0);
    repeat (4) begin
      @(negedge clock);
      check("lost_wr_sel", 64'(seg_sel), 64'h0);
      check("lost_wr_led", led, 64'h0);
    end
    wait_slot(3'd7, 1'b0, "rst7_wait");
    check("rst7_sel", 64'(seg_sel), 64'h0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
